scc_ram_arbiter: RTL and testbench
==================================

// Module: scc_ram_arbiter
// PURPOSE
//  Shares the single external cartridge RAM port (ramreq/ramwrt/ramadr/ramdbi/ramdbo) between two
//  req/ack masters: port A (SCC mapper wrapper) and port B (ROM image loader / debug master).
//  Round-robin, one transaction in flight, fixed RAM read latency. Sits between the SCC wrapper
//  and the board RAM controller on clk21m.
// PARAMETERS
//  LATENCY  2   ramreq-to-ramdbi-valid cycles, legal range 1..15
// PORTS
//  clk21m    in   1   system clock, 21.47727MHz (single clock)
//  reset     in   1   synchronous reset, active-high
//  req_a     in   1   port A request level, held until ack_a
//  wrt_a     in   1   port A: 1 = write, 0 = read (valid with req_a)
//  adr_a     in   21  port A byte address
//  dbo_a     in   8   port A write data
//  ack_a     out  1   port A completion, one-cycle pulse
//  dbi_a     out  8   port A read data, valid from ack_a, held until next A read completes
//  req_b/wrt_b/adr_b/dbo_b/ack_b/dbi_b: same as port A, for port B
//  ramreq    out  1   RAM request, one-cycle pulse
//  ramwrt    out  1   RAM write strobe qualifier (valid with ramreq)
//  ramadr    out  21  RAM address (valid with ramreq)
//  ramdbo    out  8   RAM write data (valid with ramreq)
//  ramdbi    in   8   RAM read data, valid exactly LATENCY cycles after ramreq
//  busy      out  1   high in any state other than IDLE
// BEHAVIOUR
//  - Reset (sync): state=IDLE; ack_a=ack_b=ramreq=ramwrt=0; ramadr=0; ramdbo=0; dbi_a=dbi_b=0;
//    busy=0; last_served=B (so A wins the first tie). Reset mid-transaction aborts it: no ack issued.
//  - FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE. All outputs registered.
//  - IDLE (cycle T): if any req: pick winner, latch wrt/adr/dbo and grant id, go ISSUE.
//    Only one req: that port wins. Both req: port != last_served wins; last_served <= winner.
//  - ISSUE (T+1): ramreq=1 with ramwrt/ramadr/ramdbo from latched values; counter <= LATENCY-1;
//    go WAIT.
//  - WAIT: decrement counter each cycle; in cycle T+1+LATENCY (counter==0): if read,
//    capture ramdbi into dbi of granted port; go ACK.
//  - ACK (T+2+LATENCY): ack of granted port = 1 for exactly this cycle; go IDLE.
//  - Throughput: one transaction per LATENCY+3 cycles. IDLE at T+3+LATENCY re-samples reqs;
//    a master must drop req on the cycle after seeing ack, else a new transaction starts.
//  - Writes: ramdbi ignored, dbi of the port unchanged; ack timing identical to reads.
//  - Req dropped before ack (protocol violation): transaction still completes, ack still pulses.
//  - Req of the losing port is never lost: it stays pending and is granted at the next IDLE.
//  - ack_a and ack_b are never high in the same cycle; ramreq never high outside ISSUE.
//  - ramadr/ramwrt/ramdbo hold their last values outside ISSUE (no bus toggling).
// TESTING
//  - Single A read, LATENCY=2, adr_a=0x1A000: ramreq at T+1 with ramadr=0x1A000, ramwrt=0;
//    ramdbi=0x5C at T+3 -> ack_a at T+4, dbi_a=0x5C; ack_b stays 0.
//  - Simultaneous req_a/req_b after reset -> A served first, B ramreq at A-ack+2;
//    repeat both held -> strict A,B,A,B alternation.
//  - B write adr_b=0x00123 dbo_b=0xA5 -> ramreq with ramwrt=1, ramadr=0x00123, ramdbo=0xA5;
//    ack_b at T+4; dbi_b unchanged.
//  - Reset asserted during WAIT -> next cycle all outputs at reset values, no ack;
//    a following A request is granted normally.
//  - LATENCY=1 and LATENCY=15 builds: ack exactly at T+2+LATENCY, data sampled in correct cycle.
//  - Back-to-back A reads with req held 1 cycle after ack -> one extra transaction issued,
//    documenting the req-drop rule.

Source files
------------

// File: rtl/scc_ram_arbiter_if.sv
// Bundle of the two master req/ack ports and the external cartridge RAM port.
// The arbiter connects through the slave modport; a driver of the masters and the RAM model uses master.
interface scc_ram_arbiter_if;
    localparam int unsigned ADR_W = 21;
    localparam int unsigned DAT_W = 8;

    logic             req_a;
    logic             wrt_a;
    logic [ADR_W-1:0] adr_a;
    logic [DAT_W-1:0] dbo_a;
    logic             ack_a;
    logic [DAT_W-1:0] dbi_a;

    logic             req_b;
    logic             wrt_b;
    logic [ADR_W-1:0] adr_b;
    logic [DAT_W-1:0] dbo_b;
    logic             ack_b;
    logic [DAT_W-1:0] dbi_b;

    logic             ramreq;
    logic             ramwrt;
    logic [ADR_W-1:0] ramadr;
    logic [DAT_W-1:0] ramdbo;
    logic [DAT_W-1:0] ramdbi;
    logic             busy;

    modport slave (
        input  req_a, wrt_a, adr_a, dbo_a,
        input  req_b, wrt_b, adr_b, dbo_b,
        input  ramdbi,
        output ack_a, dbi_a, ack_b, dbi_b,
        output ramreq, ramwrt, ramadr, ramdbo, busy
    );

    modport master (
        output req_a, wrt_a, adr_a, dbo_a,
        output req_b, wrt_b, adr_b, dbo_b,
        output ramdbi,
        input  ack_a, dbi_a, ack_b, dbi_b,
        input  ramreq, ramwrt, ramadr, ramdbo, busy
    );
endinterface

// File: rtl/scc_ram_arbiter.sv
// Round-robin arbiter sharing one fixed-latency cartridge RAM port between two req/ack masters.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> ACK -> IDLE, every output registered.
module scc_ram_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic                clk21m,
    input  logic                reset,
    scc_ram_arbiter_if.slave    bus
);
    localparam int unsigned ADR_W = 21;
    localparam int unsigned DAT_W = 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t             r_state,  w_state_n;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_n;
    logic               r_last_b, w_last_b_n;
    logic               r_gnt_b,  w_gnt_b_n;
    logic               r_ack_a,  w_ack_a_n;
    logic               r_ack_b,  w_ack_b_n;
    logic               r_ramreq, w_ramreq_n;
    logic               r_ramwrt, w_ramwrt_n;
    logic [ADR_W-1:0]   r_ramadr, w_ramadr_n;
    logic [DAT_W-1:0]   r_ramdbo, w_ramdbo_n;
    logic [DAT_W-1:0]   r_dbi_a,  w_dbi_a_n;
    logic [DAT_W-1:0]   r_dbi_b,  w_dbi_b_n;
    logic               r_busy,   w_busy_n;
    logic               w_both;
    logic               w_win_b;

    // On a tie the port that was not served last wins; a lone request always wins.
    assign w_both  = bus.req_a & bus.req_b;
    assign w_win_b = w_both ? ~r_last_b : bus.req_b;

    // Next-state and next-output logic; the RAM bus registers double as the transaction latch.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_last_b_n = r_last_b;
        w_gnt_b_n  = r_gnt_b;
        w_ack_a_n  = 1'b0;
        w_ack_b_n  = 1'b0;
        w_ramreq_n = 1'b0;
        w_ramwrt_n = r_ramwrt;
        w_ramadr_n = r_ramadr;
        w_ramdbo_n = r_ramdbo;
        w_dbi_a_n  = r_dbi_a;
        w_dbi_b_n  = r_dbi_b;

        case (r_state)
            S_IDLE: begin
                if (bus.req_a | bus.req_b) begin
                    w_gnt_b_n  = w_win_b;
                    if (w_both) begin
                        w_last_b_n = w_win_b;
                    end
                    w_ramreq_n = 1'b1;
                    w_ramwrt_n = w_win_b ? bus.wrt_b : bus.wrt_a;
                    w_ramadr_n = w_win_b ? bus.adr_b : bus.adr_a;
                    w_ramdbo_n = w_win_b ? bus.dbo_b : bus.dbo_a;
                    w_state_n  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_n   = CNT_W'(LATENCY - 1);
                w_state_n = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    if (!r_ramwrt) begin
                        if (r_gnt_b) begin
                            w_dbi_b_n = bus.ramdbi;
                        end else begin
                            w_dbi_a_n = bus.ramdbi;
                        end
                    end
                    w_ack_a_n = ~r_gnt_b;
                    w_ack_b_n = r_gnt_b;
                    w_state_n = S_ACK;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
            S_ACK: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        w_busy_n = (w_state_n != S_IDLE);
    end

    // State and output registers; reset aborts any transaction without an ack.
    always_ff @(posedge clk21m) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_last_b <= 1'b1;
            r_gnt_b  <= 1'b0;
            r_ack_a  <= 1'b0;
            r_ack_b  <= 1'b0;
            r_ramreq <= 1'b0;
            r_ramwrt <= 1'b0;
            r_ramadr <= '0;
            r_ramdbo <= '0;
            r_dbi_a  <= '0;
            r_dbi_b  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_last_b <= w_last_b_n;
            r_gnt_b  <= w_gnt_b_n;
            r_ack_a  <= w_ack_a_n;
            r_ack_b  <= w_ack_b_n;
            r_ramreq <= w_ramreq_n;
            r_ramwrt <= w_ramwrt_n;
            r_ramadr <= w_ramadr_n;
            r_ramdbo <= w_ramdbo_n;
            r_dbi_a  <= w_dbi_a_n;
            r_dbi_b  <= w_dbi_b_n;
            r_busy   <= w_busy_n;
        end
    end

    assign bus.ack_a  = r_ack_a;
    assign bus.ack_b  = r_ack_b;
    assign bus.dbi_a  = r_dbi_a;
    assign bus.dbi_b  = r_dbi_b;
    assign bus.ramreq = r_ramreq;
    assign bus.ramwrt = r_ramwrt;
    assign bus.ramadr = r_ramadr;
    assign bus.ramdbo = r_ramdbo;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_scc_ram_arbiter.sv
// Bench for scc_ram_arbiter: three lanes (LATENCY 2, 1, 15) share one stimulus and are each
// tracked by a transaction-timeline model; lane 0 also gets table vectors and directed sequences.
module tb_scc_ram_arbiter;
    localparam int NL = 3;

    function automatic int unsigned lat_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    logic        clk21m = 1'b0;
    logic        reset  = 1'b1;
    logic        req_a = 1'b0, wrt_a = 1'b0, req_b = 1'b0, wrt_b = 1'b0;
    logic [20:0] adr_a = '0, adr_b = '0;
    logic [7:0]  dbo_a = '0, dbo_b = '0, ramdbi = '0;

    always #5 clk21m = ~clk21m;

    logic [NL-1:0] w_ack_a, w_ack_b, w_ramreq, w_ramwrt, w_busy;
    logic [20:0]   w_ramadr [NL];
    logic [7:0]    w_ramdbo [NL];
    logic [7:0]    w_dbi_a  [NL];
    logic [7:0]    w_dbi_b  [NL];

    for (genvar g = 0; g < NL; g++) begin : g_lane
        scc_ram_arbiter_if u_if ();
        assign u_if.req_a  = req_a;
        assign u_if.wrt_a  = wrt_a;
        assign u_if.adr_a  = adr_a;
        assign u_if.dbo_a  = dbo_a;
        assign u_if.req_b  = req_b;
        assign u_if.wrt_b  = wrt_b;
        assign u_if.adr_b  = adr_b;
        assign u_if.dbo_b  = dbo_b;
        assign u_if.ramdbi = ramdbi;
        assign w_ack_a[g]  = u_if.ack_a;
        assign w_ack_b[g]  = u_if.ack_b;
        assign w_ramreq[g] = u_if.ramreq;
        assign w_ramwrt[g] = u_if.ramwrt;
        assign w_busy[g]   = u_if.busy;
        assign w_ramadr[g] = u_if.ramadr;
        assign w_ramdbo[g] = u_if.ramdbo;
        assign w_dbi_a[g]  = u_if.dbi_a;
        assign w_dbi_b[g]  = u_if.dbi_b;

        scc_ram_arbiter #(.LATENCY(lat_of(g))) u_dut (
            .clk21m (clk21m),
            .reset  (reset),
            .bus    (u_if.slave)
        );
    end

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Inputs as sampled by the coming clock edge.
    logic        s_reset = 1'b1, s_req_a = 1'b0, s_wrt_a = 1'b0, s_req_b = 1'b0, s_wrt_b = 1'b0;
    logic [20:0] s_adr_a = '0, s_adr_b = '0;
    logic [7:0]  s_dbo_a = '0, s_dbo_b = '0, s_ramdbi = '0;

    // Model: a transaction granted at edge E pulses ramreq after E, samples ramdbi at E+L+1,
    // acks after E+L+1 and is idle again after E+L+2.
    bit          m_act    [NL];
    bit          m_last_b [NL];
    bit          m_gnt_b  [NL];
    bit          m_ramwrt [NL];
    int          m_e      [NL];
    logic [20:0] m_ramadr [NL];
    logic [7:0]  m_ramdbo [NL];
    logic [7:0]  m_dbi_a  [NL];
    logic [7:0]  m_dbi_b  [NL];

    typedef struct {
        logic        req_a, req_b, wrt_a, wrt_b;
        logic [20:0] adr_a, adr_b;
        logic [7:0]  dbo_a, dbo_b, rdata;
        logic        exp_b;
        logic [20:0] exp_adr;
        logic        exp_wrt;
        logic [7:0]  exp_dbo, exp_dbi;
    } vec_t;
    vec_t vt [7];

    int   ak_t [$];
    bit   ak_b [$];
    int   rq_t [$];
    logic [7:0] hist [32];
    int   rq_i [NL];
    int   ak_i [NL];
    int   cnt_ack, cnt_rq, found;

    task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h (t=%0t)", name, lane, act, exp, $time);
        end
    endtask

    task automatic model_check();
        for (int g = 0; g < NL; g++) begin
            int lat;
            int k;
            bit win_b;
            lat = int'(lat_of(g));
            if (s_reset) begin
                m_act[g] = 1'b0;  m_last_b[g] = 1'b1; m_gnt_b[g] = 1'b0; m_ramwrt[g] = 1'b0;
                m_ramadr[g] = '0; m_ramdbo[g] = '0;   m_dbi_a[g] = '0;   m_dbi_b[g] = '0;
            end else if (!m_act[g]) begin
                if (s_req_a || s_req_b) begin
                    win_b = (s_req_a && s_req_b) ? !m_last_b[g] : s_req_b;
                    if (s_req_a && s_req_b) m_last_b[g] = win_b;
                    m_gnt_b[g]  = win_b;
                    m_act[g]    = 1'b1;
                    m_e[g]      = edge_n;
                    m_ramwrt[g] = win_b ? s_wrt_b : s_wrt_a;
                    m_ramadr[g] = win_b ? s_adr_b : s_adr_a;
                    m_ramdbo[g] = win_b ? s_dbo_b : s_dbo_a;
                end
            end else begin
                k = edge_n - m_e[g];
                if (k == lat + 1 && !m_ramwrt[g]) begin
                    if (m_gnt_b[g]) m_dbi_b[g] = s_ramdbi;
                    else            m_dbi_a[g] = s_ramdbi;
                end
                if (k == lat + 2) m_act[g] = 1'b0;
            end
            k = edge_n - m_e[g];
            chk("m_ack_a",  g, 32'(w_ack_a[g]),  32'(m_act[g] && k == lat + 1 && !m_gnt_b[g]));
            chk("m_ack_b",  g, 32'(w_ack_b[g]),  32'(m_act[g] && k == lat + 1 && m_gnt_b[g]));
            chk("m_ramreq", g, 32'(w_ramreq[g]), 32'(m_act[g] && k == 0));
            chk("m_busy",   g, 32'(w_busy[g]),   32'(m_act[g]));
            chk("m_rambus", g, 32'({w_ramwrt[g], w_ramdbo[g], w_ramadr[g]}),
                               32'({m_ramwrt[g], m_ramdbo[g], m_ramadr[g]}));
            chk("m_dbi_a",  g, 32'(w_dbi_a[g]),  32'(m_dbi_a[g]));
            chk("m_dbi_b",  g, 32'(w_dbi_b[g]),  32'(m_dbi_b[g]));
        end
    endtask

    // One clock: model check at negedge, then return 1 time unit after the posedge.
    task automatic tick();
        @(negedge clk21m);
        model_check();
        s_reset = reset;  s_req_a = req_a; s_wrt_a = wrt_a; s_adr_a = adr_a; s_dbo_a = dbo_a;
        s_req_b = req_b;  s_wrt_b = wrt_b; s_adr_b = adr_b; s_dbo_b = dbo_b; s_ramdbi = ramdbi;
        edge_n++;
        @(posedge clk21m);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        rqa  rqb  wra  wrb  adr_a       adr_b      dboa   dbob   rdata  expB exp_adr    ewrt edbo   edbi
        vt[0] = '{1'b1,1'b0,1'b0,1'b0,21'h1A000, 21'h00000, 8'h3C, 8'h00, 8'h5C, 1'b0,21'h1A000, 1'b0,8'h3C, 8'h5C};
        vt[1] = '{1'b0,1'b1,1'b0,1'b1,21'h00000, 21'h00123, 8'h00, 8'hA5, 8'h77, 1'b1,21'h00123, 1'b1,8'hA5, 8'h00};
        vt[2] = '{1'b1,1'b1,1'b0,1'b0,21'h00010, 21'h00020, 8'h01, 8'h02, 8'h11, 1'b0,21'h00010, 1'b0,8'h01, 8'h11};
        vt[3] = '{1'b1,1'b1,1'b0,1'b0,21'h00030, 21'h00040, 8'h03, 8'h04, 8'h22, 1'b1,21'h00040, 1'b0,8'h04, 8'h22};
        vt[4] = '{1'b1,1'b1,1'b1,1'b0,21'h1FFFFF,21'h00050, 8'hFF, 8'h05, 8'h33, 1'b0,21'h1FFFFF,1'b1,8'hFF, 8'h11};
        vt[5] = '{1'b0,1'b1,1'b0,1'b0,21'h00000, 21'h0ABCD, 8'h00, 8'h06, 8'h44, 1'b1,21'h0ABCD, 1'b0,8'h06, 8'h44};
        vt[6] = '{1'b1,1'b1,1'b0,1'b0,21'h00001, 21'h00002, 8'h07, 8'h08, 8'h55, 1'b1,21'h00002, 1'b0,8'h08, 8'h55};

        reset = 1'b1;
        tick(); tick();
        chk("reset_outputs", 0, 32'({w_ack_a[0], w_ack_b[0], w_ramreq[0], w_ramwrt[0], w_busy[0]}), 32'(0));
        chk("reset_adr", 0, 32'(w_ramadr[0]), 32'(0));
        reset = 1'b0;
        tick();

        // Table vectors on lane 0: each one is a complete transaction with fixed timing.
        for (int i = 0; i < 7; i++) begin
            req_a = vt[i].req_a; wrt_a = vt[i].wrt_a; adr_a = vt[i].adr_a; dbo_a = vt[i].dbo_a;
            req_b = vt[i].req_b; wrt_b = vt[i].wrt_b; adr_b = vt[i].adr_b; dbo_b = vt[i].dbo_b;
            ramdbi = vt[i].rdata;
            tick();
            chk("tv_ramreq", 0, 32'(w_ramreq[0]), 32'(1));
            chk("tv_rambus", 0, 32'({w_ramwrt[0], w_ramdbo[0], w_ramadr[0]}),
                                32'({vt[i].exp_wrt, vt[i].exp_dbo, vt[i].exp_adr}));
            tick(); tick();
            chk("tv_early_ack", 0, 32'({w_ack_b[0], w_ack_a[0]}), 32'(0));
            tick();
            chk("tv_ack", 0, 32'({w_ack_b[0], w_ack_a[0]}), vt[i].exp_b ? 32'(2) : 32'(1));
            chk("tv_dbi", 0, 32'(vt[i].exp_b ? w_dbi_b[0] : w_dbi_a[0]), 32'(vt[i].exp_dbi));
            req_a = 1'b0; req_b = 1'b0;
            tick(); tick();
        end

        // Reset during WAIT aborts without an ack; the next request is served normally.
        req_a = 1'b1; wrt_a = 1'b0; adr_a = 21'h00777;
        tick(); tick();
        chk("wait_busy", 0, 32'(w_busy[0]), 32'(1));
        req_a = 1'b0; reset = 1'b1;
        tick();
        chk("rst_mid_ctl", 0, 32'({w_ack_a[0], w_ack_b[0], w_ramreq[0], w_ramwrt[0], w_busy[0]}), 32'(0));
        chk("rst_mid_bus", 0, 32'({w_ramdbo[0], w_ramadr[0]}), 32'(0));
        chk("rst_mid_dbi", 0, 32'({w_dbi_a[0], w_dbi_b[0]}), 32'(0));
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_ack_after_rst", 0, 32'({w_ack_a[0], w_ack_b[0]}), 32'(0));
        end
        req_a = 1'b1; adr_a = 21'h00888; ramdbi = 8'h9E;
        tick();
        chk("post_rst_ramreq", 0, 32'({w_ramreq[0], w_ramadr[0]}), 32'({1'b1, 21'h00888}));
        tick(); tick(); tick();
        chk("post_rst_ack", 0, 32'({w_ack_a[0], w_dbi_a[0]}), 32'({1'b1, 8'h9E}));
        req_a = 1'b0;
        tick(); tick();

        // Both requests held from reset: A first, then strict alternation every 5 cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0; req_a = 1'b1; req_b = 1'b1; wrt_a = 1'b0; wrt_b = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            ramdbi = 8'($urandom);
            tick();
            if (w_ramreq[0]) rq_t.push_back(i);
            if (w_ack_a[0] || w_ack_b[0]) begin
                ak_t.push_back(i);
                ak_b.push_back(w_ack_b[0]);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        chk("alt_count", 0, 32'(ak_t.size()), 32'(8));
        for (int i = 0; i < ak_b.size(); i++) chk("alt_order", i, 32'(ak_b[i]), 32'(i % 2));
        if (ak_t.size() > 0 && rq_t.size() > 1) chk("b_ramreq_gap", 0, 32'(rq_t[1]), 32'(ak_t[0] + 2));
        else chk("b_ramreq_gap_missing", 0, 32'(rq_t.size()), 32'(2));
        tick(); tick();

        // Request held through the IDLE cycle after ack starts one extra transaction.
        req_a = 1'b1; adr_a = 21'h00100;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (w_ack_a[0]) found = 1;
        end
        chk("b2b_first_ack", 0, 32'(found), 32'(1));
        tick(); tick();
        chk("b2b_extra_ramreq", 0, 32'(w_ramreq[0]), 32'(1));
        req_a = 1'b0;
        cnt_ack = 0; cnt_rq = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cnt_ack += int'(w_ack_a[0]);
            cnt_rq  += int'(w_ramreq[0]);
        end
        chk("b2b_extra_ack", 0, 32'(cnt_ack), 32'(1));
        chk("b2b_no_third", 0, 32'(cnt_rq), 32'(0));

        // Latency lanes: one-cycle A read pulse, distinct ramdbi every cycle.
        reset = 1'b1;
        tick();
        reset = 1'b0; req_a = 1'b1; wrt_a = 1'b0; adr_a = 21'h00ABC;
        for (int g = 0; g < NL; g++) begin rq_i[g] = -1; ak_i[g] = -1; end
        for (int i = 0; i < 32; i++) begin
            tick();
            if (i == 0) req_a = 1'b0;
            for (int g = 0; g < NL; g++) begin
                if (w_ramreq[g] && rq_i[g] < 0) rq_i[g] = i;
                if (w_ack_a[g]  && ak_i[g] < 0) ak_i[g] = i;
            end
            hist[i] = 8'(i * 37 + 11);
            ramdbi  = hist[i];
        end
        for (int g = 0; g < NL; g++) begin
            chk("lat_ramreq", g, 32'(rq_i[g]), 32'(0));
            chk("lat_ack", g, 32'(ak_i[g] - rq_i[g]), 32'(lat_of(g) + 1));
            if (rq_i[g] >= 0 && rq_i[g] + int'(lat_of(g)) < 32)
                chk("lat_dbi", g, 32'(w_dbi_a[g]), 32'(hist[rq_i[g] + int'(lat_of(g))]));
            else
                chk("lat_dbi_noreq", g, 32'(rq_i[g]), 32'(0));
        end

        // Randomized masters (mostly well-behaved, occasional early drop and reset).
        for (int i = 0; i < 3000; i++) begin
            ramdbi = 8'($urandom);
            reset  = ($urandom_range(0, 599) == 0);
            if (req_a && w_ack_a[0]) req_a = 1'b0;
            else if (!req_a && $urandom_range(0, 3) == 0) begin
                req_a = 1'b1; wrt_a = 1'($urandom); adr_a = 21'($urandom); dbo_a = 8'($urandom);
            end else if (req_a && $urandom_range(0, 63) == 0) req_a = 1'b0;
            if (req_b && w_ack_b[0]) req_b = 1'b0;
            else if (!req_b && $urandom_range(0, 3) == 0) begin
                req_b = 1'b1; wrt_b = 1'($urandom); adr_b = 21'($urandom); dbo_b = 8'($urandom);
            end else if (req_b && $urandom_range(0, 63) == 0) req_b = 1'b0;
            tick();
        end
        reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
